// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
// Shared definitions for the GPIO controller: register byte offsets, the
// register count, and the byte-enable merge helper used by every write path.
// -----------------------------------------------------------------------------
package gpio_pkg;

  // Number of mapped word registers (0x00 .. 0x24). Anything above reads 0 and
  // flags err.
  localparam int NUM_REGS = 10;

  // Byte offsets within the 64-byte window (decoded on addr[5:2]).
  localparam logic [5:0] OFS_DATA_OUT = 6'h00;
  localparam logic [5:0] OFS_SET      = 6'h04;
  localparam logic [5:0] OFS_CLR      = 6'h08;
  localparam logic [5:0] OFS_TGL      = 6'h0C;
  localparam logic [5:0] OFS_DIR      = 6'h10;
  localparam logic [5:0] OFS_DATA_IN  = 6'h14;
  localparam logic [5:0] OFS_IRQ_EN   = 6'h18;
  localparam logic [5:0] OFS_RISE_EN  = 6'h1C;
  localparam logic [5:0] OFS_FALL_EN  = 6'h20;
  localparam logic [5:0] OFS_IRQ_STAT = 6'h24;

  // Byte-merged write: lanes with be=1 take wdata, the rest keep old.
  // Atomic ops pass the fully computed new value as wdata so that the byte
  // enables gate the result, not the operand.
  function automatic logic [31:0] apply_be(input logic [31:0] old,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gpio_if.sv
// -----------------------------------------------------------------------------
// Core data-bus interfaces used by the GPIO controller.
//   gpio_dat_if : addr[31:0], be[3:0], wdata[31:0]        (master -> slave)
//   gpio_ctr_if : req, we (master -> slave);
//                 gnt, rvalid, err, rdata[31:0] (slave -> master)
// -----------------------------------------------------------------------------
interface gpio_dat_if;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;

  modport Master (output addr, be, wdata);
  modport Slave  (input  addr, be, wdata);
endinterface

interface gpio_ctr_if;
  logic        req;
  logic        we;
  logic        gnt;
  logic        rvalid;
  logic        err;
  logic [31:0] rdata;

  modport Master (output req, we, input  gnt, rvalid, err, rdata);
  modport Slave  (input  req, we, output gnt, rvalid, err, rdata);
endinterface

// File: rtl/gpio_sync.sv
// -----------------------------------------------------------------------------
// gpio_sync
// Multi-flop synchroniser for asynchronous pad inputs plus one history flop
// for edge detection.
//   clk, rst_n : clock, async active-low reset
//   pin_i      : raw pad inputs (asynchronous)
//   data_in    : synchronised pin values (last chain stage)
//   rise_raw   : data_in & ~in_prev (unmasked)
//   fall_raw   : ~data_in & in_prev (unmasked)
// -----------------------------------------------------------------------------
module gpio_sync #(
  parameter int NBITS       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] pin_i,
  output logic [NBITS-1:0] data_in,
  output logic [NBITS-1:0] rise_raw,
  output logic [NBITS-1:0] fall_raw
);

  logic [NBITS-1:0] sync_q [SYNC_STAGES];
  logic [NBITS-1:0] sync_d [SYNC_STAGES];
  logic [NBITS-1:0] in_prev_q, in_prev_d;

  always_comb begin
    sync_d[0] = pin_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    in_prev_d = sync_q[SYNC_STAGES-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its neighbour's value from before the edge; blocking would collapse the
  // chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is a flop chain, not a RAM, so it is reset like any
      // other register; a pin held high through reset then yields one rise.
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      in_prev_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      in_prev_q <= in_prev_d;
    end
  end

  assign data_in  = sync_q[SYNC_STAGES-1];
  assign rise_raw = data_in & ~in_prev_q;
  assign fall_raw = ~data_in & in_prev_q;

endmodule

// File: rtl/gpio_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_ctrl
// Parametrised GPIO controller: per-pin output/direction registers with atomic
// set/clear/toggle, synchronised inputs and rise/fall edge interrupts with W1C
// status. Single-cycle, no-back-pressure bus slave.
//   Clk, Rst_n : clock, async active-low reset
//   DatBus     : addr, be, wdata
//   CtrBus     : req, we in; gnt, rvalid, err, rdata out (all registered)
//   gpio_i     : raw pad inputs, asynchronous to Clk
//   gpio_o     : DATA_OUT
//   gpio_oe    : DIR (1 = drive)
//   irq        : registered level interrupt, |(IRQ_STAT & IRQ_EN)
// -----------------------------------------------------------------------------
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int          NBITS       = 32,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] OUT_RST     = 32'h0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  gpio_dat_if.Slave        DatBus,
  gpio_ctr_if.Slave        CtrBus,
  input  logic [NBITS-1:0] gpio_i,
  output logic [NBITS-1:0] gpio_o,
  output logic [NBITS-1:0] gpio_oe,
  output logic             irq
);

  // Bits above NBITS-1 are held at 0 in every register.
  localparam logic [31:0] PIN_MASK = 32'((64'h1 << NBITS) - 64'h1);

  logic [31:0] out_q,     out_d;
  logic [31:0] dir_q,     dir_d;
  logic [31:0] irq_en_q,  irq_en_d;
  logic [31:0] rise_en_q, rise_en_d;
  logic [31:0] fall_en_q, fall_en_d;
  logic [31:0] stat_q,    stat_d;
  logic        irq_q,     irq_d;
  logic        gnt_q,     gnt_d;
  logic        rvalid_q,  rvalid_d;
  logic        err_q,     err_d;
  logic [31:0] rdata_q,   rdata_d;

  logic [NBITS-1:0] data_in, rise_raw, fall_raw;
  logic [31:0]      rise_ev, fall_ev, w1c, rd_data;
  logic [5:0]       ofs;
  logic             mapped, wr_en;
  logic [31:0]      wdata;
  logic [3:0]       be;
  logic             addr_unused;

  gpio_sync #(
    .NBITS       (NBITS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .pin_i    (gpio_i),
    .data_in  (data_in),
    .rise_raw (rise_raw),
    .fall_raw (fall_raw)
  );

  assign ofs         = {DatBus.addr[5:2], 2'b00};
  assign mapped      = DatBus.addr[5:2] < 4'(NUM_REGS);
  assign wr_en       = CtrBus.req & CtrBus.we;
  assign wdata       = DatBus.wdata;
  assign be          = DatBus.be;
  assign addr_unused = ^{DatBus.addr[31:6], DatBus.addr[1:0]};

  // Edges are qualified by the enables but not by DIR, so driven pins can
  // raise their own interrupts.
  assign rise_ev = 32'(rise_raw) & rise_en_q;
  assign fall_ev = 32'(fall_raw) & fall_en_q;

  // Read mux sees pre-write state; SET/CLR/TGL and unmapped offsets read 0.
  always_comb begin
    rd_data = '0;
    case (ofs)
      OFS_DATA_OUT: rd_data = out_q;
      OFS_DIR:      rd_data = dir_q;
      OFS_DATA_IN:  rd_data = 32'(data_in);
      OFS_IRQ_EN:   rd_data = irq_en_q;
      OFS_RISE_EN:  rd_data = rise_en_q;
      OFS_FALL_EN:  rd_data = fall_en_q;
      OFS_IRQ_STAT: rd_data = stat_q;
      default:      rd_data = '0;
    endcase
  end

  always_comb begin
    // NOTE: each _d starts from its held value, so no branch below leaves a
    // variable unassigned and no latch can be inferred.
    out_d     = out_q;
    dir_d     = dir_q;
    irq_en_d  = irq_en_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;

    if (wr_en) begin
      case (ofs)
        OFS_DATA_OUT: out_d     = apply_be(out_q, wdata, be) & PIN_MASK;
        OFS_SET:      out_d     = apply_be(out_q, out_q | wdata, be) & PIN_MASK;
        OFS_CLR:      out_d     = apply_be(out_q, out_q & ~wdata, be) & PIN_MASK;
        OFS_TGL:      out_d     = apply_be(out_q, out_q ^ wdata, be) & PIN_MASK;
        OFS_DIR:      dir_d     = apply_be(dir_q, wdata, be) & PIN_MASK;
        OFS_IRQ_EN:   irq_en_d  = apply_be(irq_en_q, wdata, be) & PIN_MASK;
        OFS_RISE_EN:  rise_en_d = apply_be(rise_en_q, wdata, be) & PIN_MASK;
        OFS_FALL_EN:  fall_en_d = apply_be(fall_en_q, wdata, be) & PIN_MASK;
        OFS_IRQ_STAT: w1c       = apply_be(32'h0, wdata, be);
        default:      ;
      endcase
    end

    // Hardware set is OR-ed in after the clear, so it wins a collision.
    stat_d   = ((stat_q & ~w1c) | rise_ev | fall_ev) & PIN_MASK;
    irq_d    = |(stat_q & irq_en_q);

    gnt_d    = CtrBus.req;
    rvalid_d = CtrBus.req;
    err_d    = CtrBus.req & ~mapped;
    rdata_d  = CtrBus.req ? rd_data : rdata_q;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_q     <= OUT_RST & PIN_MASK;
      dir_q     <= '0;
      irq_en_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      irq_q     <= 1'b0;
      gnt_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      irq_en_q  <= irq_en_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      stat_q    <= stat_d;
      irq_q     <= irq_d;
      gnt_q     <= gnt_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign gpio_o        = out_q[NBITS-1:0];
  assign gpio_oe       = dir_q[NBITS-1:0];
  assign irq           = irq_q;
  assign CtrBus.gnt    = gnt_q;
  assign CtrBus.rvalid = rvalid_q;
  assign CtrBus.err    = err_q;
  assign CtrBus.rdata  = rdata_q;

endmodule
